// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: shares one UDP transmit engine between the audio cache
// stream (port A) and the control/status stream (port B). Packets are
// granted one at a time with round-robin fairness. An inter-packet gap and
// a completion timeout are enforced.
module udp_tx_arbiter #(
  parameter logic [15:0] MAX_BYTES   = 16'd1472,
  parameter logic [7:0]  GAP_CYC     = 8'd4,
  parameter logic [23:0] TIMEOUT_CYC = 24'd1_000_000
) (
  input  logic        eth_tx_clk,
  input  logic        rst,
  input  logic        a_tx_start_en,
  input  logic [15:0] a_tx_byte_num,
  input  logic [31:0] a_tx_data,
  output logic        a_tx_req,
  output logic        a_tx_done,
  input  logic        b_tx_start_en,
  input  logic [15:0] b_tx_byte_num,
  input  logic [31:0] b_tx_data,
  output logic        b_tx_req,
  output logic        b_tx_done,
  output logic        udp_tx_start_en,
  output logic [15:0] udp_tx_byte_num,
  output logic [31:0] udp_tx_data,
  input  logic        udp_tx_req,
  input  logic        udp_tx_done,
  output logic        drop,
  output logic        timeout
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;   // 0 = A, 1 = B
  logic        last_q, last_d;     // 0 = A, 1 = B
  logic        pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic [15:0] len_a_q, len_a_d, len_b_q, len_b_d;
  logic [15:0] bn_q, bn_d;
  logic [23:0] tmr_q, tmr_d;
  logic [7:0]  gap_q, gap_d;
  logic        done_a_q, done_a_d, done_b_q, done_b_d;
  logic        drop_q, drop_d;

  logic in_wait, busy_a, busy_b, acc_a, acc_b, tmo_hit;

  // A source counts as granted while its packet is being started or sent.
  assign in_wait = (state_q == S_WAIT);
  assign busy_a  = (state_q == S_START || in_wait) && !grant_q;
  assign busy_b  = (state_q == S_START || in_wait) &&  grant_q;
  assign acc_a   = a_tx_start_en && (a_tx_byte_num != '0) &&
                   (a_tx_byte_num <= MAX_BYTES) && !pend_a_q && !busy_a;
  assign acc_b   = b_tx_start_en && (b_tx_byte_num != '0) &&
                   (b_tx_byte_num <= MAX_BYTES) && !pend_b_q && !busy_b;
  assign tmo_hit = in_wait && !udp_tx_done && (tmr_q == TIMEOUT_CYC - 24'd1);

  assign udp_tx_start_en = (state_q == S_START);
  assign udp_tx_byte_num = bn_q;
  assign udp_tx_data     = in_wait ? (grant_q ? b_tx_data : a_tx_data) : '0;
  assign a_tx_req        = in_wait && !grant_q && udp_tx_req;
  assign b_tx_req        = in_wait &&  grant_q && udp_tx_req;
  assign a_tx_done       = done_a_q;
  assign b_tx_done       = done_b_q;
  assign drop            = drop_q;
  assign timeout         = tmo_hit;

  // Next-state: request acceptance, grant selection and packet sequencing.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    pend_a_d = pend_a_q;
    pend_b_d = pend_b_q;
    len_a_d  = len_a_q;
    len_b_d  = len_b_q;
    bn_d     = bn_q;
    tmr_d    = tmr_q;
    gap_d    = gap_q;
    done_a_d = 1'b0;
    done_b_d = 1'b0;
    // Rejects on both ports in one cycle still make a single drop pulse.
    drop_d   = (a_tx_start_en && !acc_a) || (b_tx_start_en && !acc_b);

    if (acc_a) begin
      pend_a_d = 1'b1;
      len_a_d  = a_tx_byte_num;
    end
    if (acc_b) begin
      pend_b_d = 1'b1;
      len_b_d  = b_tx_byte_num;
    end

    case (state_q)
      S_IDLE: begin
        if (pend_a_q && (!pend_b_q || last_q)) begin
          grant_d = 1'b0;
          last_d  = 1'b0;
          bn_d    = len_a_q;
          state_d = S_START;
        end else if (pend_b_q) begin
          grant_d = 1'b1;
          last_d  = 1'b1;
          bn_d    = len_b_q;
          state_d = S_START;
        end
      end
      S_START: begin
        tmr_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (udp_tx_done || tmo_hit) begin
          if (grant_q) pend_b_d = 1'b0;
          else         pend_a_d = 1'b0;
          done_a_d = udp_tx_done && !grant_q;
          done_b_d = udp_tx_done &&  grant_q;
          gap_d    = '0;
          state_d  = S_GAP;
        end else if (tmr_q != '1) begin
          tmr_d = tmr_q + 24'd1;
        end
      end
      S_GAP: begin
        if (gap_q >= GAP_CYC - 8'd1) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge eth_tx_clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
      len_a_q  <= '0;
      len_b_q  <= '0;
      bn_q     <= '0;
      tmr_q    <= '0;
      gap_q    <= '0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
      len_a_q  <= len_a_d;
      len_b_q  <= len_b_d;
      bn_q     <= bn_d;
      tmr_q    <= tmr_d;
      gap_q    <= gap_d;
      done_a_q <= done_a_d;
      done_b_q <= done_b_d;
      drop_q   <= drop_d;
    end
  end

endmodule
